// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants for the fetch stage and its users
// Purpose: default widths, the NOP encoding and the opcode constants used by decode.
// Ports: none (package).
package instruction_fetch_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    // Empty output slots are presented to decode as this word.
    localparam logic [31:0] NOP = 32'd0;

    // Opcode values shared by decode and the bench.
    localparam logic [6:0] OP_ALU = 7'd6;
    localparam logic [6:0] OP_LW  = 7'd7;
    localparam logic [6:0] OP_SW  = 7'd8;

endpackage

// File: rtl/instruction_fetch_skid.sv
// rtl/instruction_fetch_skid.sv - one-entry holding register for words returned during a stall
// Purpose: captures one ROM word and its address while decode is stalled.
// Ports:
//   i_clock, i_reset     : clock, synchronous active-high reset
//   i_load               : capture i_instr/i_pc and mark the entry full
//   i_clear              : empty the entry (wins over i_load)
//   i_instr, i_pc        : word and its address to capture
//   o_valid, o_instr, o_pc : held entry
module instruction_fetch_skid #(
    parameter int ADDR_W = instruction_fetch_pkg::ADDR_W,
    parameter int DATA_W = instruction_fetch_pkg::DATA_W
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc
);
    import instruction_fetch_pkg::*;

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_instr <= DATA_W'(NOP);
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load && !r_valid) begin
            // A full entry is never overwritten.
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, ROM addressing, stall skid and redirect squash
// Purpose: drives a 1-cycle registered instruction ROM and presents fetched words to decode.
// Ports:
//   i_clock, i_reset       : clock, synchronous active-high reset
//   i_stall                : decode not accepting; output holds
//   i_redirect, i_redirect_pc : load PC and squash in-flight work
//   o_mem_addr             : ROM address (the PC register)
//   i_mem_instr            : ROM data for the address of the previous cycle
//   o_instr, o_instr_pc, o_instr_valid : registered output to decode
module instruction_fetch #(
    parameter int ADDR_W = instruction_fetch_pkg::ADDR_W,
    parameter int DATA_W = instruction_fetch_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_instr,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_instr_pc,
    output logic              o_instr_valid
);
    import instruction_fetch_pkg::*;

    logic [ADDR_W-1:0] r_pc;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;

    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_instr;
    logic [ADDR_W-1:0] w_skid_pc;
    logic              w_skid_load;
    logic              w_skid_clear;

    // The word arriving during a stall belongs to the request issued last
    // cycle; park it so it is not lost. The word for the current PC is
    // discarded because the PC does not advance and is re-issued.
    assign w_skid_load  = i_stall && !i_redirect && r_req_valid;
    // Squash on redirect, drain into the output when decode accepts.
    assign w_skid_clear = i_redirect || (!i_stall && w_skid_valid);

    instruction_fetch_skid #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (i_mem_instr),
        .i_pc    (r_req_pc),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc          <= RESET_PC;
            r_req_valid   <= 1'b0;
            r_req_pc      <= '0;
            r_instr       <= DATA_W'(NOP);
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (i_redirect) begin
            r_pc          <= i_redirect_pc;
            r_req_valid   <= 1'b0;
            r_instr       <= DATA_W'(NOP);
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (i_stall) begin
            r_req_valid   <= 1'b0;
        end else begin
            r_pc          <= r_pc + 1'b1;
            r_req_valid   <= 1'b1;
            r_req_pc      <= r_pc;
            if (w_skid_valid) begin
                r_instr       <= w_skid_instr;
                r_instr_pc    <= w_skid_pc;
                r_instr_valid <= 1'b1;
            end else begin
                r_instr       <= r_req_valid ? i_mem_instr : DATA_W'(NOP);
                r_instr_pc    <= r_req_pc;
                r_instr_valid <= r_req_valid;
            end
        end
    end

    // Pure register copy: no path from stall/redirect to the ROM address.
    assign o_mem_addr    = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic [9:0]  mem_addr;
    logic [31:0] mem_instr;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    instruction_fetch dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_mem_addr    (mem_addr),
        .i_mem_instr   (mem_instr),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (instr_valid)
    );

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return 32'hA000_0000 + {22'd0, a};
    endfunction

    always @(posedge clock) mem_instr <= rom_word(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the output is a stream of consecutive addresses
    // starting at the last reset/redirect target, preceded by two bubble
    // edges. A stalled edge changes nothing visible.
    bit          m_on = 0;
    int          m_warm;
    logic [9:0]  m_next;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [9:0]  m_pc;

    always @(posedge clock) begin
        if (reset) begin
            m_on = 1; m_warm = 2; m_next = 10'd0;
            m_valid = 0; m_instr = 32'd0;
        end else if (redirect) begin
            m_warm = 2; m_next = redirect_pc;
            m_valid = 0; m_instr = 32'd0;
        end else if (!stall && m_on) begin
            if (m_warm > 1) begin
                m_warm--;
                m_valid = 0; m_instr = 32'd0;
            end else begin
                m_warm = 0;
                m_valid = 1; m_instr = rom_word(m_next); m_pc = m_next;
                m_next = m_next + 10'd1;
            end
        end
    end

    always @(negedge clock) begin
        if (m_on) begin
            check("model_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            check("model_instr", instr, m_instr);
            if (m_valid) check("model_pc", {22'd0, instr_pc}, {22'd0, m_pc});
        end
    end

    task automatic cyc(input logic r, input logic s, input logic d, input logic [9:0] p);
        reset = r; stall = s; redirect = d; redirect_pc = p;
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic pin(input string name, input logic [31:0] exp_instr, input logic [9:0] exp_pc,
                       input logic exp_valid);
        check({name, "_valid"}, {31'd0, instr_valid}, {31'd0, exp_valid});
        check({name, "_instr"}, instr, exp_instr);
        if (exp_valid) check({name, "_pc"}, {22'd0, instr_pc}, {22'd0, exp_pc});
    endtask

    initial begin
        reset = 1; stall = 0; redirect = 0; redirect_pc = '0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
        pin("reset", 32'd0, 10'd0, 0);

        // Reset release: valid on the 2nd edge, then one word per cycle.
        cyc(0, 0, 0, 0);
        pin("rel_e1", 32'd0, 10'd0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            pin("rel_seq", 32'hA000_0000 + i, 10'(i), 1);
        end

        // Stall 3 cycles on A0000004, then 5 and 6 with no gap.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            pin("stall_hold", 32'hA000_0004, 10'd4, 1);
        end
        cyc(0, 0, 0, 0);
        pin("stall_rel0", 32'hA000_0005, 10'd5, 1);
        cyc(0, 0, 0, 0);
        pin("stall_rel1", 32'hA000_0006, 10'd6, 1);

        // Redirect to 100.
        cyc(0, 0, 1, 10'd100);
        pin("redir_b0", 32'd0, 10'd0, 0);
        check("redir_mem_addr", {22'd0, mem_addr}, 32'd100);
        cyc(0, 0, 0, 0);
        pin("redir_b1", 32'd0, 10'd0, 0);
        cyc(0, 0, 0, 0);
        pin("redir_w0", 32'hA000_0064, 10'd100, 1);
        cyc(0, 0, 0, 0);
        pin("redir_w1", 32'hA000_0065, 10'd101, 1);

        // PC wrap 1022 -> 1023 -> 0 -> 1.
        cyc(0, 0, 1, 10'd1022);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        pin("wrap0", 32'hA000_03FE, 10'd1022, 1);
        cyc(0, 0, 0, 0);
        pin("wrap1", 32'hA000_03FF, 10'd1023, 1);
        cyc(0, 0, 0, 0);
        pin("wrap2", 32'hA000_0000, 10'd0, 1);
        cyc(0, 0, 0, 0);
        pin("wrap3", 32'hA000_0001, 10'd1, 1);

        // Stall fills the skid, then redirect+stall squashes it.
        cyc(0, 1, 0, 0);
        pin("skid_hold", 32'hA000_0001, 10'd1, 1);
        cyc(0, 1, 1, 10'd500);
        pin("squash_b0", 32'd0, 10'd0, 0);
        cyc(0, 0, 0, 0);
        pin("squash_b1", 32'd0, 10'd0, 0);
        cyc(0, 0, 0, 0);
        pin("squash_w0", 32'hA000_01F4, 10'd500, 1);

        // Reset mid-stall, then restart from 0.
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        pin("rst_stall", 32'd0, 10'd0, 0);
        check("rst_stall_mem_addr", {22'd0, mem_addr}, 32'd0);
        cyc(0, 0, 0, 0);
        pin("restart_b", 32'd0, 10'd0, 0);
        cyc(0, 0, 0, 0);
        pin("restart_w0", 32'hA000_0000, 10'd0, 1);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic r, s, d;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 99) < 35);
            d = ($urandom_range(0, 99) < 4);
            cyc(r, s, d, 10'($urandom_range(0, 1023)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that drives the instruction ROM address and presents fetched instructions to decode. It owns the program counter, accounts for the ROM's one-cycle registered read latency, and holds its output under a decode-side stall without losing or duplicating instructions. It accepts a PC redirect with squash. Empty slots are presented as NOP (32'd0).

## Interface
- ADDR_W, 10, PC / ROM address width (1024 words)
- DATA_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  decode not accepting; hold output
- redirect  in  1  load PC from redirect_pc, squash in-flight work
- redirect_pc  in  ADDR_W  redirect target
- mem_addr  out  ADDR_W  ROM address; combinational copy of PC register
- mem_instr  in  DATA_W  ROM data, valid one cycle after address
- instr  out  DATA_W  registered instruction to decode; 0 when not valid
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  instr is a real fetched instruction

## Operation
- Registers: pc; req_valid, req_pc (request issued last cycle); skid_valid, skid_instr, skid_pc (one-entry holding buffer); output regs.
- Reset values: pc=RESET_PC, req_valid=0, skid_valid=0, instr=0, instr_pc=0, instr_valid=0. mem_addr=RESET_PC during reset.
- Priority per cycle: reset > redirect > stall > normal.
- Normal (no stall, no redirect):
  - pc<=pc+1, wrapping 1023->0.
  - req_valid<=1, req_pc<=pc.
  - If skid_valid: output<=skid and skid_valid<=0.
  - Else output<=(mem_instr, req_pc, req_valid). When req_valid=0, instr<=0.
- Stall (no redirect):
  - pc, output regs and output valid hold; req_valid<=0.
  - If req_valid=1, capture mem_instr/req_pc into skid (skid_valid<=1).
  - The skid is never overwritten while full. By construction, req_valid=0 whenever skid_valid=1.
- Redirect (stall ignored):
  - pc<=redirect_pc; req_valid<=0; skid_valid<=0.
  - instr_valid<=0, instr<=0, instr_pc<=0.
- mem_instr is sampled only when req_valid=1. ROM data returned for addresses issued during stall is discarded. Those addresses are re-issued because pc did not advance.

## Timing
- Fetch latency: 2 edges from PC issue to instr_valid. Edge 1 is the ROM register; edge 2 is the output register.
- After reset falls: first instr_valid=1 (instr=rom[RESET_PC]) at the 2nd rising edge with reset=0. Then one instruction per cycle.
- Stall release: the cycle after stall drops, output advances to the skid entry if one is held, otherwise to the next in-flight word. There are no gaps, no duplicates and no drops across any stall length ≥1.
- Redirect at edge E: instr_valid=0 after E and after E+1. instr=rom[redirect_pc] with instr_valid=1 after E+2.
- Redirect during stall: the squash takes effect; the held instruction is dropped.
- Reset mid-stall or mid-redirect: full reset values at the next edge.
- Throughput 1 instr/cycle when unstalled. No combinational path from stall/redirect to mem_addr; mem_addr depends only on pc.

## Structure
- Shared package holds:
  - ADDR_W, DATA_W and NOP=32'd0.
  - Opcode constants LW=7, SW=8, ALU=6, used by decode and bench.
- Sub-module fetch_skid: one-entry holding register with valid, load and clear. This isolates the stall capture logic.
- PC increment and output mux stay in the top.

## Test plan
Bench pairs the fetch stage with a 1-cycle registered ROM model preloaded with rom[i]=32'hA000_0000+i.
- Reset release, no stall -> instr_valid rises on the 2nd edge. Sequence is instr=A0000000, A0000001, A0000002… with instr_pc 0,1,2 on consecutive cycles.
- stall=1 for 3 cycles while instr=A0000004 -> output holds A0000004 for 4 cycles. Then A0000005, A0000006 follow with no gap or duplicate.
- redirect=1, redirect_pc=10'd100 -> two cycles of instr_valid=0/instr=0, then A0000064 (pc 100), A0000065.
- Run from pc 1022 -> instr_pc 1022, 1023, 0, 1 with matching data (A00003FE, A00003FF, A0000000).
- redirect=1 and stall=1 in the same cycle with skid full -> held word is dropped; rom[redirect_pc] arrives 2 edges later.
- reset=1 asserted for one cycle mid-stall -> instr=0, instr_valid=0, mem_addr=0 next edge, then restart as in the first scenario.
